// File: rtl/bits_pkg.sv
// bits_pkg: shared widths and the in-flight read tag for the bits request arbiter
package bits_pkg;
  localparam int BITS_WORD_W = 32;
  localparam int BITS_LEN_W = 4;
  localparam int BITS_OUT_W = 15;
  localparam int BITS_ID_W = 3;
  typedef struct packed {
    logic valid;
    logic [BITS_ID_W-1:0] id;
    logic [BITS_LEN_W-1:0] len;
  } bits_tag_t;
endpackage

// File: rtl/bits_rr_arbiter.sv
// bits_rr_arbiter: combinational round-robin picker, first eligible at or after rr wins
// ports: elig (per-requester eligibility), rr (priority pointer) -> gnt (one-hot), id (granted index)
module bits_rr_arbiter
  import bits_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]      elig,
  input  logic [BITS_ID_W-1:0] rr,
  output logic [NREQ-1:0]      gnt,
  output logic [BITS_ID_W-1:0] id
);
  // Scan from farthest to nearest so the requester closest to rr is the last write.
  always_comb begin
    gnt = '0;
    id = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (elig[(int'(rr) + k) % NREQ]) begin
        gnt = NREQ'(1) << ((int'(rr) + k) % NREQ);
        id = BITS_ID_W'((int'(rr) + k) % NREQ);
      end
    end
  end
endmodule

// File: rtl/bits_req_arbiter.sv
// bits_req_arbiter: throttles 32-bit pushes into the bits FIFO, round-robin shares its read port, routes results back
// ports: clk, rst (async active-low); src_* upstream words; fifo_* FIFO push/read/result; req_* requesters;
//        rsp_* steered results; level (buffered bits); err (sticky check, built only with BITS_ARB_CHECK_EN)
module bits_req_arbiter
  import bits_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int CAP_BITS = 1024,
  parameter int LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       src_valid,
  input  logic [BITS_WORD_W-1:0]     src_data,
  output logic                       src_ready,
  output logic                       fifo_pushin,
  output logic [BITS_WORD_W-1:0]     fifo_datain,
  output logic                       fifo_reqin,
  output logic [BITS_LEN_W-1:0]      fifo_reqlen,
  input  logic                       fifo_pushout,
  input  logic [BITS_LEN_W-1:0]      fifo_lenout,
  input  logic [BITS_OUT_W-1:0]      fifo_dataout,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [BITS_LEN_W*NREQ-1:0] req_len,
  output logic [NREQ-1:0]            req_ready,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [BITS_OUT_W-1:0]      rsp_data,
  output logic [BITS_LEN_W-1:0]      rsp_len,
  output logic [10:0]                level,
  output logic                       err
);
  logic [BITS_ID_W-1:0] rr, gid;
  logic [NREQ-1:0] elig, gnt;
  logic [BITS_LEN_W-1:0] glen;
  bits_tag_t tags [LAT];
  bits_tag_t tag_out;
  assign src_ready = level <= 11'(CAP_BITS - BITS_WORD_W);
  assign fifo_pushin = src_valid && src_ready;
  assign fifo_datain = src_data;
  // Zero-length requests pass the level compare trivially, so they are always eligible.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) elig[i] = req_valid[i] && (11'(req_len[BITS_LEN_W*i +: BITS_LEN_W]) <= level);
  end
  bits_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .elig (elig),
    .rr   (rr),
    .gnt  (gnt),
    .id   (gid)
  );
  assign glen = req_len[BITS_LEN_W*int'(gid) +: BITS_LEN_W];
  assign req_ready = gnt;
  assign fifo_reqin = |gnt;
  assign fifo_reqlen = fifo_reqin ? glen : '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= '0;
      rr <= '0;
    end else begin
      level <= level + (fifo_pushin ? 11'(BITS_WORD_W) : 11'd0) - 11'(fifo_reqlen);
      if (fifo_reqin) rr <= (int'(gid) == NREQ - 1) ? '0 : gid + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) tags[i] <= '0;
    end else begin
      tags[0] <= '{valid: fifo_reqin, id: gid, len: fifo_reqlen};
      for (int i = 1; i < LAT; i++) tags[i] <= tags[i-1];
    end
  end
  assign tag_out = tags[LAT-1];
  assign rsp_valid = (fifo_pushout && tag_out.valid) ? NREQ'(1) << tag_out.id : '0;
  assign rsp_data = fifo_dataout;
  assign rsp_len = fifo_lenout;
`ifdef BITS_ARB_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err <= 1'b0;
    else if ((fifo_pushout != tag_out.valid) || (fifo_pushout && tag_out.valid && fifo_lenout != tag_out.len)) err <= 1'b1;
  end
`else
  logic unused_tag_len;
  assign unused_tag_len = ^tag_out.len;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_bits_req_arbiter.sv
// tb_bits_req_arbiter: directed vectors against a behavioural bit FIFO with LAT=2 read latency
module tb_bits_req_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic src_valid, src_ready, fifo_pushin, fifo_reqin, fifo_pushout, err;
  logic [31:0] src_data, fifo_datain;
  logic [3:0] fifo_reqlen, fifo_lenout, rsp_len;
  logic [14:0] fifo_dataout, rsp_data;
  logic [3:0] req_valid, req_ready, rsp_valid;
  logic [15:0] req_len;
  logic [10:0] level;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  bits_req_arbiter #(.NREQ(4), .CAP_BITS(1024), .LAT(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .src_valid    (src_valid),
    .src_data     (src_data),
    .src_ready    (src_ready),
    .fifo_pushin  (fifo_pushin),
    .fifo_datain  (fifo_datain),
    .fifo_reqin   (fifo_reqin),
    .fifo_reqlen  (fifo_reqlen),
    .fifo_pushout (fifo_pushout),
    .fifo_lenout  (fifo_lenout),
    .fifo_dataout (fifo_dataout),
    .req_valid    (req_valid),
    .req_len      (req_len),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_len      (rsp_len),
    .level        (level),
    .err          (err)
  );
  bit q[$];
  logic p1v, p2v;
  logic [3:0] p1l, p2l;
  logic [14:0] p1d, p2d;
  always @(posedge clk or negedge rst) begin
    logic [14:0] d;
    if (!rst) begin
      q.delete();
      p1v <= 1'b0;
      p2v <= 1'b0;
      p1l <= '0;
      p2l <= '0;
      p1d <= '0;
      p2d <= '0;
    end else begin
      d = '0;
      if (fifo_reqin) for (int i = 0; i < int'(fifo_reqlen); i++) d[i] = q.pop_front();
      if (fifo_pushin) for (int i = 0; i < 32; i++) q.push_back(fifo_datain[i]);
      p1v <= fifo_reqin;
      p1l <= fifo_reqlen;
      p1d <= d;
      p2v <= p1v;
      p2l <= p1l;
      p2d <= p1d;
    end
  end
  assign fifo_pushout = p2v;
  assign fifo_lenout = p2v ? p2l : 4'd0;
  assign fifo_dataout = p2v ? p2d : 15'd0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    src_valid = 1'b0;
    src_data = '0;
    req_valid = '0;
    req_len = '0;
  endtask
  task automatic rst_pulse;
    tick();
    rst = 1'b0;
    idle();
    #4;
    chk("rst_level", 32'(level), 0);
    tick();
    rst = 1'b1;
    #4;
  endtask
  initial begin
    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #4;
    chk("reset_level", 32'(level), 0);
    chk("reset_src_ready", 32'(src_ready), 1);
    chk("reset_req_ready", 32'(req_ready), 0);
    chk("reset_reqin", 32'(fifo_reqin), 0);
    chk("reset_pushin", 32'(fifo_pushin), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_err", 32'(err), 0);
    tick();
    src_valid = 1'b1;
    src_data = 32'hDEADBEEF;
    #4;
    chk("single_pushin", 32'(fifo_pushin), 1);
    chk("single_datain", fifo_datain, 32'hDEADBEEF);
    tick();
    idle();
    req_valid = 4'b0001;
    req_len = 16'h0008;
    #4;
    chk("single_grant", 32'(req_ready), 32'h1);
    chk("single_reqlen", 32'(fifo_reqlen), 8);
    chk("single_level32", 32'(level), 32);
    tick();
    idle();
    #4;
    chk("single_level24", 32'(level), 24);
    chk("single_no_rsp_yet", 32'(rsp_valid), 0);
    tick();
    #4;
    chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("single_rsp_data", 32'(rsp_data), 32'h0EF);
    chk("single_rsp_len", 32'(rsp_len), 8);
    rst_pulse();
    src_valid = 1'b1;
    src_data = 32'h12345678;
    tick();
    idle();
    req_valid = 4'hF;
    req_len = 16'hFFFF;
    #4;
    chk("rr_grant0", 32'(req_ready), 32'h1);
    chk("rr_level32", 32'(level), 32);
    tick();
    #4;
    chk("rr_grant1", 32'(req_ready), 32'h2);
    chk("rr_level17", 32'(level), 17);
    tick();
    src_valid = 1'b1;
    src_data = 32'hFFFFFFFF;
    #4;
    chk("rr_starved", 32'(req_ready), 0);
    chk("rr_level2", 32'(level), 2);
    chk("rr_rsp0", 32'(rsp_valid), 32'h1);
    chk("rr_rsp0_data", 32'(rsp_data), 32'h5678);
    tick();
    src_valid = 1'b0;
    #4;
    chk("rr_grant2", 32'(req_ready), 32'h4);
    chk("rr_level34", 32'(level), 34);
    chk("rr_rsp1", 32'(rsp_valid), 32'h2);
    chk("rr_rsp1_data", 32'(rsp_data), 32'h2468);
    tick();
    #4;
    chk("rr_grant3", 32'(req_ready), 32'h8);
    chk("rr_level19", 32'(level), 19);
    chk("rr_rsp_gap", 32'(rsp_valid), 0);
    tick();
    idle();
    #4;
    chk("rr_level4", 32'(level), 4);
    chk("rr_rsp2", 32'(rsp_valid), 32'h4);
    chk("rr_rsp2_data", 32'(rsp_data), 32'h7FFC);
    tick();
    #4;
    chk("rr_rsp3", 32'(rsp_valid), 32'h8);
    chk("rr_rsp3_data", 32'(rsp_data), 32'h7FFF);
    rst_pulse();
    for (int i = 0; i < 40; i++) begin
      src_valid = 1'b1;
      src_data = 32'(i);
      #4;
      chk("full_pushin", 32'(fifo_pushin), 32'(i < 32));
      chk("full_src_ready", 32'(src_ready), 32'(i < 32));
      tick();
    end
    idle();
    #4;
    chk("full_level", 32'(level), 1024);
    rst_pulse();
    src_valid = 1'b1;
    src_data = 32'hAAAAAAAA;
    tick();
    idle();
    req_valid = 4'b0001;
    req_len = 16'h000F;
    #4;
    chk("sim_pre_grant_a", 32'(req_ready), 32'h1);
    tick();
    req_len = 16'h0007;
    #4;
    chk("sim_pre_grant_b", 32'(req_ready), 32'h1);
    chk("sim_level17", 32'(level), 17);
    tick();
    req_valid = 4'b0010;
    req_len = 16'h0050;
    src_valid = 1'b1;
    src_data = 32'h55555555;
    #4;
    chk("sim_level10", 32'(level), 10);
    chk("sim_grant1", 32'(req_ready), 32'h2);
    chk("sim_reqlen", 32'(fifo_reqlen), 5);
    chk("sim_pushin", 32'(fifo_pushin), 1);
    tick();
    idle();
    #4;
    chk("sim_level37", 32'(level), 37);
    tick();
    req_valid = 4'b0100;
    req_len = 16'h0400;
    #4;
    chk("mid_grant2", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b1000;
    req_len = 16'h4000;
    #4;
    chk("mid_grant3", 32'(req_ready), 32'h8);
    tick();
    idle();
    rst = 1'b0;
    #4;
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_src_ready", 32'(src_ready), 1);
    chk("mid_rst_rsp", 32'(rsp_valid), 0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #4;
      chk("mid_after_rsp", 32'(rsp_valid), 0);
      chk("mid_after_level", 32'(level), 0);
      chk("mid_after_err", 32'(err), 0);
      tick();
    end
    req_valid = 4'b0001;
    req_len = 16'h0000;
    #4;
    chk("zero_grant", 32'(req_ready), 32'h1);
    chk("zero_reqin", 32'(fifo_reqin), 1);
    tick();
    idle();
    tick();
    #4;
    chk("zero_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("zero_rsp_data", 32'(rsp_data), 0);
    chk("zero_rsp_len", 32'(rsp_len), 0);
    chk("final_err", 32'(err), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bits_req_arbiter.md
# bits_req_arbiter

Request scheduler for the `bits` 32-in / 0–15-bit-out bit FIFO. It throttles upstream 32-bit words against the FIFO's bit capacity and tracks the bit fill level. It shares the FIFO's read port among `NREQ` requesters using round-robin arbitration, granting only requests whose length is already buffered. It steers each read result back to the requester that issued it.

## Interface
- `NREQ`, 4: number of requesters (2–8).
- `CAP_BITS`, 1024: FIFO bit capacity; must be a multiple of 32.
- `LAT`, 2: FIFO `reqin`→`pushout` latency in cycles.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `src_valid`  in  1  upstream word valid.
- `src_data`  in  32  upstream word.
- `src_ready`  out  1  word accepted when `src_valid & src_ready`.
- `fifo_pushin`  out  1  push strobe to the FIFO; equals `src_valid & src_ready`.
- `fifo_datain`  out  32  equals `src_data`.
- `fifo_reqin`  out  1  read strobe to the FIFO; 1 when any grant is issued this cycle.
- `fifo_reqlen`  out  4  length of the granted request.
- `fifo_pushout`  in  1  FIFO result valid.
- `fifo_lenout`  in  4  FIFO result length.
- `fifo_dataout`  in  15  FIFO result bits, LSB-first.
- `req_valid`  in  NREQ  per-requester request.
- `req_len`  in  4*NREQ  request length; requester i uses bits [4i+3:4i].
- `req_ready`  out  NREQ  one-hot grant; transfer occurs when valid and ready are both high.
- `rsp_valid`  out  NREQ  one-hot response strobe.
- `rsp_data`  out  15  response bits, shared by all requesters.
- `rsp_len`  out  4  response length, shared by all requesters.
- `level`  out  11  bits currently held in the FIFO.
- `err`  out  1  sticky protocol-check flag.

## Operation
- **Level counter** (11 bits, reset 0): next = level + 32·push − len·grant. Simultaneous push and grant apply both updates in the same cycle.
- **Source flow control:** `src_ready = (level <= CAP_BITS-32)`. It uses the registered level only and is combinational.
- **Eligibility:** requester i is eligible when `req_valid[i] && req_len[i] <= level`. The eligibility check uses the registered level, so a word pushed in cycle T becomes usable from cycle T+1.
- **Arbitration:**
  - Round-robin over eligible requesters, starting at pointer `rr` (reset 0).
  - At most one grant per cycle.
  - After granting requester i, `rr` becomes (i+1) mod NREQ. `rr` is unchanged when no grant is issued.
  - An ineligible requester at `rr` does not block eligible requesters behind it.
- **Zero-length requests:** always eligible. Each is granted, issues `fifo_reqin` with `reqlen` 0, and returns a response with data 0.
- **Grant outputs:** `req_ready`, `fifo_reqin` and `fifo_reqlen` are combinational from the registered state and the current `req_valid`/`req_len`.
- **Tag pipeline:**
  - `LAT`-deep shift register of {valid, id, len}.
  - Loaded with the grant every cycle. When no grant is issued, valid is loaded as 0.
- **Response routing:**
  - `rsp_valid[id] = fifo_pushout & tag_out.valid`.
  - `rsp_data = fifo_dataout`, `rsp_len = fifo_lenout`.
  - Both are combinational pass-through from the FIFO outputs.
- **Reset:**
  - `rst` low clears `level`, `rr`, the tag pipeline and `err` immediately.
  - All outputs go to 0 except `src_ready`, which goes to 1.
  - In-flight responses are discarded. The same `rst` net drives the FIFO, so both sides empty together.

## Timing
- Grant in cycle T: the FIFO samples at edge T→T+1, and `rsp_valid` is high in cycle T+LAT.
- Back-to-back grants produce one response per cycle, in grant order.
- Push-to-eligibility latency: 1 cycle.
- No combinational path from `fifo_*` inputs to `req_ready` or `src_ready`.

## Configuration
- `BITS_ARB_CHECK_EN` defined:
  - `err` sets, and stays set until reset, when `fifo_pushout != tag_out.valid`.
  - `err` also sets when the two are both high and `fifo_lenout != tag_out.len`.
- `BITS_ARB_CHECK_EN` undefined: no compare logic is built; `err` is tied to 0.

## Structure
- Package `bits_pkg`:
  - Constants `BITS_WORD_W=32`, `BITS_LEN_W=4`, `BITS_OUT_W=15`.
  - Typedef `bits_tag_t` for {valid, id, len}.
- Sub-module `bits_rr_arbiter`: parameterised NREQ round-robin picker taking eligibility and returning a one-hot grant. Counter and tag logic stay in the top level.

## Test plan
- **Reset:** hold `rst` low, then release → `level`=0, `src_ready`=1, all other outputs 0.
- **Single read:** push 0xDEADBEEF, then req0 with len 8 in the next cycle → `req_ready[0]`=1, `rsp_valid[0]` 2 cycles later with `rsp_data`=0x0EF and `rsp_len`=8, `level`=24.
- **Starvation-free sharing:** `level`=32, all four requesters at len 15 → grants 0 then 1, after which `level`=2 and no grant. Push one word → grants 2 then 3.
- **Full:** push continuously → 32 words accepted. `src_ready` drops once `level`=1024, and `fifo_pushin` never asserts while `src_ready`=0.
- **Simultaneous push and grant:** `level`=10, push plus req1 with len 5 in the same cycle → `level`=37 next cycle.
- **Reset mid-operation:** assert `rst` with 2 grants in flight → no `rsp_valid` afterwards, `level`=0, and `err`=0 under `BITS_ARB_CHECK_EN`.
